// File: rtl/sockit_cdc_pack.sv
// Width-up packer: gathers N consecutive DW-bit beats into one N*DW-bit word with lane enables.
// An input "last" beat closes a partial word early. One beat per clock is accepted, with no gap between words.
module sockit_cdc_pack #(
  parameter int unsigned DW = 8,
  parameter int unsigned N  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DW-1:0]   ffi_bus,
  input  logic            ffi_req,
  input  logic            ffi_lst,
  output logic            ffi_grt,
  output logic [N*DW-1:0] ffo_bus,
  output logic [N-1:0]    ffo_ben,
  output logic            ffo_lst,
  output logic            ffo_req,
  input  logic            ffo_grt
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned WW = N * DW;

  logic [CW-1:0] r_cnt;
  logic [WW-1:0] r_buf;
  logic [WW-1:0] r_bus;
  logic [N-1:0]  r_ben;
  logic          r_lst;
  logic          r_req;

  logic          w_ffi_trn;
  logic          w_ffo_trn;
  logic          w_close;
  logic [WW-1:0] w_merged;
  logic [N-1:0]  w_ben;

  // A beat may only enter when the output register is free or is being emptied this cycle.
  assign ffi_grt   = rst_n & (~r_req | ffo_grt);
  assign w_ffi_trn = ffi_req & ffi_grt;
  assign w_ffo_trn = r_req & ffo_grt;
  assign w_close   = w_ffi_trn & ((r_cnt == CW'(N - 1)) | ffi_lst);

  // Assembly buffer with the incoming beat placed in lane r_cnt.
  always_comb begin
    w_merged = r_buf;
    w_ben    = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (CW'(i) == r_cnt) w_merged[i*DW +: DW] = ffi_bus;
      w_ben[i] = (CW'(i) <= r_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_buf <= '0;
      r_bus <= '0;
      r_ben <= '0;
      r_lst <= 1'b0;
      r_req <= 1'b0;
    end else begin
      if (w_ffi_trn && !w_close) begin
        r_buf <= w_merged;
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_close) begin
        r_bus <= w_merged;
        r_ben <= w_ben;
        r_lst <= ffi_lst;
        r_req <= 1'b1;
        r_cnt <= '0;
        r_buf <= '0;
      end else if (w_ffo_trn) begin
        r_req <= 1'b0;
      end
    end
  end

  assign ffo_bus = r_bus;
  assign ffo_ben = r_ben;
  assign ffo_lst = r_lst;
  assign ffo_req = r_req;

endmodule
